// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared frame-parser types and constants for uart_cmd_parser.
package uart_cmd_pkg;
    localparam int C_FRAME_LEN = 5;
    localparam logic [7:0] C_HEADER_DEF = 8'hA5;
    typedef enum logic [$clog2(C_FRAME_LEN)-1:0] {sHDR, sADDR, sDATH, sDATL, sCSUM} state_t;
endpackage

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 5-byte UART command frames into register writes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] C_HEADER = C_HEADER_DEF,
`ifdef UART_CMD_TIMEOUT_EN
    parameter int C_TIMEOUT_CYC = 100000,
`endif
    parameter int C_ERRCNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic                  rx_ack,
    output logic                  wr_en,
    output logic [7:0]            wr_addr,
    output logic [15:0]           wr_data,
    output logic                  frame_err,
    output logic [C_ERRCNT_W-1:0] err_count,
    output logic                  busy
);
    state_t     state;
    logic       holdoff;
    logic       err_q;
    logic [7:0] byte_q;
    logic [7:0] csum;
    logic [7:0] addr_q;
    logic [7:0] dath_q;
    logic [7:0] datl_q;
    logic       accept;
    logic       good;
    logic       abort;
    logic       timeout;

    assign accept = (rx_valid | rx_error) & ~holdoff;
    assign busy   = state != sHDR;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int CW = $clog2(C_TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign timeout = !accept && state != sHDR && cnt == CW'(C_TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (!rstb || accept || state == sHDR || timeout)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // The accepted byte is processed on the edge that ends its ack cycle.
    assign good  = rx_ack && !err_q && state == sCSUM && byte_q == csum;
    assign abort = (rx_ack && (err_q || (state == sCSUM && byte_q != csum))) || timeout;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= sHDR;
            holdoff   <= 1'b0;
            rx_ack    <= 1'b0;
            err_q     <= 1'b0;
            byte_q    <= '0;
            csum      <= '0;
            addr_q    <= '0;
            dath_q    <= '0;
            datl_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            rx_ack    <= accept;
            holdoff   <= accept;
            wr_en     <= good;
            frame_err <= abort;
            if (accept) begin
                byte_q <= rx_data;
                err_q  <= rx_error;
            end
            if (good) begin
                wr_addr <= addr_q;
                wr_data <= {dath_q, datl_q};
            end
            if (abort && err_count != '1)
                err_count <= err_count + 1'b1;
            if (abort)
                state <= sHDR;
            else if (rx_ack) begin
                case (state)
                    sHDR:  state <= byte_q == C_HEADER ? sADDR : sHDR;
                    sADDR: begin
                        addr_q <= byte_q;
                        csum   <= byte_q;
                        state  <= sDATH;
                    end
                    sDATH: begin
                        dath_q <= byte_q;
                        csum   <= csum ^ byte_q;
                        state  <= sDATL;
                    end
                    sDATL: begin
                        datl_q <= byte_q;
                        csum   <= csum ^ byte_q;
                        state  <= sCSUM;
                    end
                    default: state <= sHDR;
                endcase
            end
        end
    end
endmodule
